flow_key_fifo: RTL
==================

# flow_key_fifo

Buffers per-packet flow keys (source/destination IPv4 address pairs) produced by the UDP receive parser and hands them one at a time to the downstream flow-measurement logic over a valid/ready handshake. It sits directly downstream of the UDP parser in the GMII receive clock domain. It absorbs bursts of back-to-back short packets while the consumer is stalled, and it counts received, dropped and (optionally) merged keys for host readout.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2
- CNT_W, 32, width of each statistics counter

Ports:
- gmii_rx_clk  in  1  sole clock; every flop is clocked on its rising edge
- rst_n  in  1  asynchronous active-low reset
- rec_pkt_done  in  1  single-cycle pulse from the UDP parser; src/dst are valid in the same cycle
- src  in  32  source IPv4 address
- dst  in  32  destination IPv4 address
- clr  in  1  synchronous clear of the statistics counters only
- key_valid  out  1  head entry available
- key_ready  in  1  consumer accepts the head entry
- key_src  out  32  head entry source address
- key_dst  out  32  head entry destination address
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- pkt_cnt  out  CNT_W  total rec_pkt_done pulses; wraps on overflow
- drop_cnt  out  CNT_W  keys lost because the FIFO was full; saturates at all-ones

## Operation
- pop = key_valid && key_ready.
- push_req = rec_pkt_done. push = push_req && (fifo_level < DEPTH || pop).
  - When the FIFO is full, a push in the same cycle as a pop is accepted.
  - Level is unchanged in that case.
- Storage is a DEPTH-entry array of {src,dst}, with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH.
- The head is read combinationally: key_src/key_dst = mem[rd_ptr] when key_valid, otherwise 0.
- key_valid = (fifo_level != 0).
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- pkt_cnt increments by 1 on every rec_pkt_done.
- drop_cnt increments when push_req && !push, and holds at 2^CNT_W-1.
- clr has priority over any increment in the same cycle: the counter becomes 0, not 1. clr does not affect FIFO contents.
- A pop while empty is impossible, because key_valid is 0.
- key_ready while empty is ignored.

## Timing
- Reset values, all outputs:
  - key_valid=0, key_src=0, key_dst=0, fifo_level=0
  - pkt_cnt=0, drop_cnt=0
  - pointers=0
- Reset asserted mid-burst discards all queued keys immediately, asynchronously.
- Latency: a push at rising edge N makes key_valid=1, with that key, visible in the cycle after edge N. This holds when the FIFO was empty.
- A pop at edge N presents the next entry, or key_valid=0, after edge N.
- Sustained throughput is one push and one pop per cycle.
- Consumer rules:
  - May hold key_ready high continuously.
  - Must sample key_src/key_dst in the cycle where pop occurs.
  - key_valid never deasserts without a pop, except on reset.

## Configuration
- FLOW_KEY_DEDUP_EN defined:
  - A register last_key / last_vld records the most recent pushed key. last_vld is cleared by reset.
  - A rec_pkt_done whose {src,dst} equals last_key while last_vld=1 is merged: it is not pushed and not counted as a drop.
  - It is counted in an extra output port dup_cnt (CNT_W, wraps, cleared by clr and reset).
  - pkt_cnt still increments on merged keys.
- FLOW_KEY_DEDUP_EN not defined:
  - Every pulse is a push candidate.
  - The port dup_cnt does not exist.

## Structure
- Shared package flow_pkg holds:
  - IP_ADDR_W=32
  - FLOW_KEY_W=64
  - typedef flow_key_t as the packed struct {src, dst}
- One sub-module, flow_key_sfifo: a generic single-clock first-word-fall-through FIFO with push/pop/level.
- Counters and dedup logic live in flow_key_fifo.

## Test plan
- Single key: pulse with src=C0A80101, dst=C0A80102, key_ready=1 -> key_valid high one cycle after the pulse with those values, popped next edge, fifo_level returns 0.
- Fill: key_ready=0, 18 pulses with DEPTH=16 -> fifo_level=16, drop_cnt=2, pkt_cnt=18. Then key_ready=1 drains the 16 keys in push order.
- Full with simultaneous pop: FIFO full, rec_pkt_done and key_ready both high -> push accepted, drop_cnt unchanged, level stays 16, new key appears last.
- clr collision: clr coincides with rec_pkt_done when pkt_cnt=5 -> pkt_cnt=0 next cycle; FIFO gains the key.
- Reset mid-operation: 7 queued, rst_n low one cycle -> key_valid=0, fifo_level=0, counters 0 immediately. First post-reset key appears normally.
- With FLOW_KEY_DEDUP_EN: three identical pulses then one different -> 2 entries queued, dup_cnt=2, pkt_cnt=4, drop_cnt=0.

Source files
------------

// File: rtl/flow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flow_pkg
// Brief    : Shared widths and flow-key type for the flow-key buffering path.
// Revision : 1.0 - initial release
// ============================================================================
package flow_pkg;

    localparam int IP_ADDR_W  = 32;
    localparam int FLOW_KEY_W = 64;

    typedef struct packed {
        logic [IP_ADDR_W-1:0] src;
        logic [IP_ADDR_W-1:0] dst;
    } flow_key_t;

endpackage
`default_nettype wire

// File: rtl/flow_key_sfifo.sv
`default_nettype none
// ============================================================================
// Module   : flow_key_sfifo
// Brief    : Generic single-clock first-word-fall-through FIFO with level.
// Revision : 1.0 - initial release
// ============================================================================
module flow_key_sfifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     wr_acc_o,
    input  logic                     rd_rdy_i,
    output logic                     rd_vld_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] c_depth = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             w_push;
    logic             w_pop;

    assign rd_vld_o  = (level_q != '0);
    assign w_pop     = rd_vld_o && rd_rdy_i;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_push    = wr_req_i && ((level_q < c_depth) || w_pop);
    assign wr_acc_o  = w_push;
    assign level_o   = level_q;
    assign rd_data_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flow_key_fifo.sv
`default_nettype none
// ============================================================================
// Module   : flow_key_fifo
// Brief    : Flow-key buffer between UDP parser and flow measurement, with
//            received/dropped counters. Define FLOW_KEY_DEDUP_EN to merge
//            back-to-back identical keys and expose dup_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module flow_key_fifo
    import flow_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     gmii_rx_clk,
    input  logic                     rst_n,
    input  logic                     rec_pkt_done,
    input  logic [31:0]              src,
    input  logic [31:0]              dst,
    input  logic                     clr,
    output logic                     key_valid,
    input  logic                     key_ready,
    output logic [31:0]              key_src,
    output logic [31:0]              key_dst,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         drop_cnt
`ifdef FLOW_KEY_DEDUP_EN
    ,
    output logic [CNT_W-1:0]         dup_cnt
`endif
);

    flow_key_t        w_in_key;
    flow_key_t        w_head_key;
    logic             w_push_req;
    logic             w_push_acc;
    logic             w_drop;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign w_in_key.src = src;
    assign w_in_key.dst = dst;

`ifdef FLOW_KEY_DEDUP_EN
    flow_key_t        last_key_q, last_key_d;
    logic             last_vld_q, last_vld_d;
    logic             w_merge;
    logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;

    assign w_merge    = rec_pkt_done && last_vld_q && (w_in_key == last_key_q);
    assign w_push_req = rec_pkt_done && !w_merge;
    assign dup_cnt    = dup_cnt_q;

    // Only keys that actually entered the FIFO become the merge reference.
    always_comb begin
        last_key_d = last_key_q;
        last_vld_d = last_vld_q;
        dup_cnt_d  = dup_cnt_q;
        if (w_push_acc) begin
            last_key_d = w_in_key;
            last_vld_d = 1'b1;
        end
        if (clr) begin
            dup_cnt_d = '0;
        end else if (w_merge) begin
            dup_cnt_d = dup_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key_q <= '0;
            last_vld_q <= 1'b0;
            dup_cnt_q  <= '0;
        end else begin
            last_key_q <= last_key_d;
            last_vld_q <= last_vld_d;
            dup_cnt_q  <= dup_cnt_d;
        end
    end
`else
    assign w_push_req = rec_pkt_done;
`endif

    flow_key_sfifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLOW_KEY_W)
    ) u_sfifo (
        .clk       (gmii_rx_clk),
        .rst_n     (rst_n),
        .wr_req_i  (w_push_req),
        .wr_data_i (w_in_key),
        .wr_acc_o  (w_push_acc),
        .rd_rdy_i  (key_ready),
        .rd_vld_o  (key_valid),
        .rd_data_o (w_head_key),
        .level_o   (fifo_level)
    );

    assign key_src = w_head_key.src;
    assign key_dst = w_head_key.dst;
    assign w_drop  = w_push_req && !w_push_acc;

    // clr wins over a coincident increment so the host sees a true zero.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            pkt_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (rec_pkt_done) begin
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end
            if (w_drop && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire
